// File: rtl/pattern_count_engine_if.sv
// pattern_count_engine_if: start/done handshake plus data-memory bus for the
// pattern count engine.
//   start        request into the engine
//   done         level acknowledge from the engine
//   mem_addr     data-memory address driven by the engine
//   mem_rd_data  combinational read data returned by memory
//   mem_wr_en    single-cycle write strobe
//   mem_wr_data  write data
// master: the engine side. slave: the requester/memory side.
interface pattern_count_engine_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;

    modport master (
        input  start,
        input  mem_rd_data,
        output done,
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data
    );

    modport slave (
        output start,
        output mem_rd_data,
        input  done,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data
    );
endinterface

// File: rtl/pattern_count_engine.sv
// pattern_count_engine: hardware responder for the program-3 start/done
// handshake. On start it reads the 5-bit pattern (mem[PAT_ADDR][7:3]) and the
// NBYTES-byte message, counts pattern matches and writes the counts to
// mem[RES_ADDR..], then raises done.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pattern_count_engine_if.master (start/done + data-memory bus)
// Optional feature macro: PATCNT_CROSS_EN enables the byte-boundary-crossing
// count (cts) and its write to mem[RES_ADDR+2].
module pattern_count_engine #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned NBYTES   = 32,
    parameter int unsigned PAT_ADDR = 32,
    parameter int unsigned RES_ADDR = 33
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pattern_count_engine_if.master bus
);
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PAT_W = 5;

    typedef enum logic [2:0] {
        IDLE,
        RD_PAT,
        SCAN,
        WR_B,
        WR_O,
`ifdef PATCNT_CROSS_EN
        WR_S,
`endif
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   ctb_q, ctb_d;
    logic [CNT_W-1:0]   cto_q, cto_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wr_en_q, wr_en_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic [2:0]         n_in;
`ifdef PATCNT_CROSS_EN
    logic [CNT_W-1:0]   cts_q, cts_d;
    logic [7:0]         prev_q, prev_d;
    logic [2:0]         n_cross;
`endif

    // Number of 5-bit windows fully inside one byte that equal the pattern.
    function automatic logic [2:0] count_in(input logic [7:0] b, input logic [PAT_W-1:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (b[k +: 5] == p) n = n + 3'd1;
        end
        return n;
    endfunction

`ifdef PATCNT_CROSS_EN
    // Windows spanning previous byte LSBs and current byte MSBs.
    function automatic logic [2:0] count_cross(input logic [15:0] w, input logic [PAT_W-1:0] p);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 4; k < 8; k++) begin
            if (w[k +: 5] == p) n = n + 3'd1;
        end
        return n;
    endfunction
`endif

    // State and registered-output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pat_q     <= '0;
            idx_q     <= '0;
            ctb_q     <= '0;
            cto_q     <= '0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
`ifdef PATCNT_CROSS_EN
            cts_q     <= '0;
            prev_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            ctb_q     <= ctb_d;
            cto_q     <= cto_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
`ifdef PATCNT_CROSS_EN
            cts_q     <= cts_d;
            prev_q    <= prev_d;
`endif
        end
    end

    // Next state; bus outputs are computed for the state being entered so
    // the registered address lines up with the cycle that consumes its data.
    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        idx_d     = idx_q;
        ctb_d     = ctb_q;
        cto_d     = cto_q;
        done_d    = done_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        n_in      = count_in(bus.mem_rd_data, pat_q);
`ifdef PATCNT_CROSS_EN
        cts_d     = cts_q;
        prev_d    = prev_q;
        // No crossing window exists before the first byte.
        n_cross   = (idx_q != '0) ? count_cross({prev_q, bus.mem_rd_data}, pat_q) : 3'd0;
`endif

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RD_PAT;
                    ctb_d   = '0;
                    cto_d   = '0;
`ifdef PATCNT_CROSS_EN
                    cts_d   = '0;
`endif
                    done_d  = 1'b0;
                    addr_d  = ADDR_W'(PAT_ADDR);
                end
            end
            RD_PAT: begin
                pat_d   = bus.mem_rd_data[7:3];
                idx_d   = '0;
                addr_d  = '0;
                state_d = SCAN;
            end
            SCAN: begin
                ctb_d = ctb_q + CNT_W'(n_in);
                cto_d = cto_q + CNT_W'(n_in != 3'd0);
`ifdef PATCNT_CROSS_EN
                cts_d  = cts_q + CNT_W'(n_in) + CNT_W'(n_cross);
                prev_d = bus.mem_rd_data;
`endif
                if (idx_q == IDX_W'(NBYTES - 1)) begin
                    state_d   = WR_B;
                    addr_d    = ADDR_W'(RES_ADDR);
                    wr_en_d   = 1'b1;
                    wr_data_d = ctb_d;
                end else begin
                    idx_d  = idx_q + IDX_W'(1);
                    addr_d = ADDR_W'(idx_q + IDX_W'(1));
                end
            end
            WR_B: begin
                state_d   = WR_O;
                addr_d    = ADDR_W'(RES_ADDR + 1);
                wr_en_d   = 1'b1;
                wr_data_d = cto_q;
            end
`ifdef PATCNT_CROSS_EN
            WR_O: begin
                state_d   = WR_S;
                addr_d    = ADDR_W'(RES_ADDR + 2);
                wr_en_d   = 1'b1;
                wr_data_d = cts_q;
            end
            WR_S: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`else
            WR_O: begin
                state_d = DONE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.done        = done_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_data = wr_data_q;
endmodule

// File: tb/tb_pattern_count_engine.sv
// tb_pattern_count_engine: directed self-checking bench for
// pattern_count_engine with a behavioural 256-byte data memory.
module tb_pattern_count_engine;
`ifdef PATCNT_CROSS_EN
    localparam bit CROSS = 1'b1;
`else
    localparam bit CROSS = 1'b0;
`endif
    localparam int         LATENCY = CROSS ? 36 : 35;
    localparam int         NWR     = CROSS ? 3 : 2;
    localparam logic [7:0] SENT    = 8'hEE;

    // fill, byte5, byte6, pattern byte, expected ctb, cto, cts
    localparam logic [7:0] T_FILL [5] = '{8'h00, 8'h55, 8'hFF, 8'hFF, 8'h00};
    localparam logic [7:0] T_B5   [5] = '{8'h00, 8'h55, 8'hFF, 8'hFF, 8'h07};
    localparam logic [7:0] T_B6   [5] = '{8'h00, 8'h55, 8'hFF, 8'hFF, 8'hC0};
    localparam logic [7:0] T_PAT  [5] = '{8'h00, 8'hA8, 8'h00, 8'hF8, 8'hF8};
    localparam logic [7:0] T_EB   [5] = '{8'd128, 8'd64, 8'd0, 8'd128, 8'd0};
    localparam logic [7:0] T_EO   [5] = '{8'd32, 8'd32, 8'd0, 8'd32, 8'd0};
    localparam logic [7:0] T_ES   [5] = '{8'd252, 8'd126, 8'd0, 8'd252, 8'd1};

    logic clk = 1'b0;
    logic rst_n;
    logic load;
    int   wr_cnt;
    int   tests_run;
    int   tests_failed;
    logic [7:0] mem [0:255];
    logic [7:0] img [0:255];

    pattern_count_engine_if #(.ADDR_W(8)) bus ();

    pattern_count_engine #(
        .ADDR_W(8), .NBYTES(32), .PAT_ADDR(32), .RES_ADDR(33)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.mem_rd_data = mem[bus.mem_addr];

    // Memory: bulk load from img, otherwise DUT writes on the rising edge.
    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
            wr_cnt <= 0;
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic load_image(input logic [7:0] fill, input logic [7:0] b5,
                              input logic [7:0] b6, input logic [7:0] pat);
        for (int i = 0; i < 256; i++) img[i] = SENT;
        for (int i = 0; i < 32; i++) img[i] = fill;
        img[5]  = b5;
        img[6]  = b6;
        img[32] = pat;
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    // Leaves the caller at the negedge after the sampling edge E0.
    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    // Bounded wait for done; cycles counts edges after E0.
    task automatic wait_done(inout int cycles);
        while (bus.done !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_en: got %b expected 0", bus.mem_wr_en); end
        tests_run++; if (bus.mem_addr !== 8'd0) begin tests_failed++; $display("FAIL reset_addr: got %0d expected 0", bus.mem_addr); end
        tests_run++; if (bus.mem_wr_data !== 8'd0) begin tests_failed++; $display("FAIL reset_wr_data: got %0d expected 0", bus.mem_wr_data); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL idle_done: got %b expected 0", bus.done); end
    endtask

    task automatic test_counts();
        int cyc;
        for (int r = 0; r < 5; r++) begin
            load_image(T_FILL[r], T_B5[r], T_B6[r], T_PAT[r]);
            pulse_start();
            cyc = 0;
            wait_done(cyc);
            tests_run++; if (cyc != LATENCY) begin tests_failed++; $display("FAIL counts%0d_latency: got %0d expected %0d", r, cyc, LATENCY); end
            tests_run++; if (mem[33] !== T_EB[r]) begin tests_failed++; $display("FAIL counts%0d_ctb: got %0d expected %0d", r, mem[33], T_EB[r]); end
            tests_run++; if (mem[34] !== T_EO[r]) begin tests_failed++; $display("FAIL counts%0d_cto: got %0d expected %0d", r, mem[34], T_EO[r]); end
            tests_run++; if (mem[35] !== (CROSS ? T_ES[r] : SENT)) begin tests_failed++; $display("FAIL counts%0d_cts: got %0d expected %0d", r, mem[35], CROSS ? T_ES[r] : SENT); end
            tests_run++; if (wr_cnt != NWR) begin tests_failed++; $display("FAIL counts%0d_writes: got %0d expected %0d", r, wr_cnt, NWR); end
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        load_image(8'h00, 8'h00, 8'h00, 8'h00);
        pulse_start();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b expected 0", bus.done); end
        tests_run++; if (bus.mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL midrst_wr_en: got %b expected 0", bus.mem_wr_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++; if (mem[33] !== SENT || mem[34] !== SENT || mem[35] !== SENT) begin tests_failed++; $display("FAIL midrst_untouched: got %h %h %h expected %h", mem[33], mem[34], mem[35], SENT); end
        tests_run++; if (wr_cnt != 0) begin tests_failed++; $display("FAIL midrst_writes: got %0d expected 0", wr_cnt); end
        pulse_start();
        cyc = 0;
        wait_done(cyc);
        tests_run++; if (cyc != LATENCY) begin tests_failed++; $display("FAIL restart_latency: got %0d expected %0d", cyc, LATENCY); end
        tests_run++; if (mem[33] !== 8'd128 || mem[34] !== 8'd32) begin tests_failed++; $display("FAIL restart_results: got %0d %0d expected 128 32", mem[33], mem[34]); end
        tests_run++; if (mem[35] !== (CROSS ? 8'd252 : SENT)) begin tests_failed++; $display("FAIL restart_cts: got %0d expected %0d", mem[35], CROSS ? 8'd252 : SENT); end
    endtask

    task automatic test_reset_during_write();
        load_image(8'h55, 8'h55, 8'h55, 8'hA8);
        pulse_start();
        repeat (34) @(negedge clk);
        tests_run++; if (bus.mem_wr_en !== 1'b1) begin tests_failed++; $display("FAIL wrrst_pre_wr_en: got %b expected 1", bus.mem_wr_en); end
        rst_n = 1'b0;
        #1;
        tests_run++; if (bus.mem_wr_en !== 1'b0) begin tests_failed++; $display("FAIL wrrst_wr_en: got %b expected 0", bus.mem_wr_en); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++; if (mem[33] !== 8'd64) begin tests_failed++; $display("FAIL wrrst_kept: got %0d expected 64", mem[33]); end
        tests_run++; if (mem[34] !== SENT || mem[35] !== SENT) begin tests_failed++; $display("FAIL wrrst_untouched: got %h %h expected %h", mem[34], mem[35], SENT); end
        tests_run++; if (wr_cnt != 1) begin tests_failed++; $display("FAIL wrrst_writes: got %0d expected 1", wr_cnt); end
    endtask

    task automatic test_start_ignored();
        int cyc;
        load_image(8'hFF, 8'hFF, 8'hFF, 8'hF8);
        pulse_start();
        repeat (10) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 11;
        wait_done(cyc);
        tests_run++; if (cyc != LATENCY) begin tests_failed++; $display("FAIL ignore_latency: got %0d expected %0d", cyc, LATENCY); end
        tests_run++; if (mem[33] !== 8'd128 || mem[34] !== 8'd32) begin tests_failed++; $display("FAIL ignore_results: got %0d %0d expected 128 32", mem[33], mem[34]); end
        repeat (5) @(negedge clk);
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL ignore_done_hold: got %b expected 1", bus.done); end
        tests_run++; if (wr_cnt != NWR) begin tests_failed++; $display("FAIL ignore_writes: got %0d expected %0d", wr_cnt, NWR); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        load_image(8'h00, 8'h07, 8'hC0, 8'hF8);
        tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("FAIL b2b_pre_done: got %b expected 1", bus.done); end
        pulse_start();
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_drop: got %b expected 0", bus.done); end
        cyc = 0;
        wait_done(cyc);
        tests_run++; if (cyc != LATENCY) begin tests_failed++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, LATENCY); end
        tests_run++; if (mem[33] !== 8'd0 || mem[34] !== 8'd0) begin tests_failed++; $display("FAIL b2b_results: got %0d %0d expected 0 0", mem[33], mem[34]); end
        tests_run++; if (mem[35] !== (CROSS ? 8'd1 : SENT)) begin tests_failed++; $display("FAIL b2b_cts: got %0d expected %0d", mem[35], CROSS ? 8'd1 : SENT); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_counts();
        test_reset_mid_run();
        test_reset_during_write();
        test_start_ignored();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
